rose_event_arbiter: RTL

- Detects rising edges on N_REQ asynchronous-in-meaning but clock-synchronous level signals and queues one pending event per channel.
- Serialises pending events to a single shared consumer over a valid/ready port, using round-robin priority.
- Sits between the stimulus/status signals under check and the shared event-logging/checker resource, so the resource sees one event at a time.

---
 rtl/rose_arb_pkg.sv | 39 +++
 rtl/rr_pick.sv | 25 ++
 rtl/rose_event_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/rose_arb_pkg.sv
// Shared types and helpers for the rising-edge event arbiter.
// Holds the FSM state enum, default sizes and the round-robin search.
package rose_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int RR_MAX    = 16;

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  typedef struct packed {
    logic       any;
    logic [3:0] idx;
  } rr_res_t;

  // First set bit of pend[n-1:0] searching ptr, ptr+1, ... modulo n.
  function automatic rr_res_t rr_first(
    input logic [RR_MAX-1:0] pend,
    input int unsigned       ptr,
    input int unsigned       n
  );
    rr_res_t     r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !r.any && pend[j[3:0]]) begin
        r.any = 1'b1;
        r.idx = j[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Reports whether any request is set and the first one from rr_ptr.
module rr_pick
  import rose_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  rr_res_t           res;
  logic [RR_MAX-1:0] pend16;

  always_comb begin
    pend16 = RR_MAX'(pending);
    res    = rr_first(pend16, 32'(rr_ptr), N_REQ);
    any    = res.any;
    idx    = res.idx[ID_W-1:0];
  end

endmodule

// File: rtl/rose_event_arbiter.sv
// Rising-edge detector with one pending event per channel,
// serialised round-robin onto a single valid/ready consumer.
module rose_event_arbiter
  import rose_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] sig_in,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_REQ-1:0] ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] evt_count
);

  state_t           state;
  state_t           state_n;
  logic [N_REQ-1:0] prev;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] acc_vec;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  ptr_n;
  logic [ID_W-1:0]  id_n;
  logic [ID_W-1:0]  id_inc;
  logic             valid_n;
  logic             accept;
  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  assign accept  = evt_valid & evt_ready;
  assign rise    = sig_in & ~prev;
  assign acc_vec = accept ? (N_REQ'(1) << evt_id) : '0;
  assign id_inc  = (evt_id == ID_W'(N_REQ - 1)) ? '0 : evt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= sig_in;
      pending   <= '0;
      ovf       <= '0;
      evt_count <= '0;
    end else begin
      prev    <= sig_in;
      pending <= (pending & ~acc_vec) | rise;
      // a fresh drop beats a simultaneous clear
      ovf     <= (ovf_clr ? '0 : ovf) | (rise & pending & ~acc_vec);
      if (accept && evt_count != '1)
        evt_count <= evt_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_n;
      evt_valid <= valid_n;
      evt_id    <= id_n;
      rr_ptr    <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    valid_n = evt_valid;
    id_n    = evt_id;
    ptr_n   = rr_ptr;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (pick_any) begin
          valid_n = 1'b1;
          id_n    = pick_idx;
          state_n = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          valid_n = 1'b0;
          ptr_n   = id_inc;
          state_n = IDLE;
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule
